mix_columns_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 29 ++
 rtl/multibly_col_by_row.sv | 28 ++
 rtl/mix_columns_seq.sv | 115 +++++++++++
 tb/tb_mix_columns_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES MixColumns definitions: matrix row constants, FSM states, byte geometry.
// Consumed by mix_columns_seq and multibly_col_by_row.
package aes_pkg;

  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 16;
  localparam int STATE_W   = BYTE_W * NUM_BYTES;

  localparam logic [31:0] MIX_ROW0 = 32'h02030101;
  localparam logic [31:0] MIX_ROW1 = 32'h01020301;
  localparam logic [31:0] MIX_ROW2 = 32'h01010203;
  localparam logic [31:0] MIX_ROW3 = 32'h03010102;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mix_state_t;

  function automatic logic [31:0] mix_row(input logic [1:0] r);
    case (r)
      2'd0:    mix_row = MIX_ROW0;
      2'd1:    mix_row = MIX_ROW1;
      2'd2:    mix_row = MIX_ROW2;
      default: mix_row = MIX_ROW3;
    endcase
  endfunction

endpackage

// File: rtl/multibly_col_by_row.sv
// Dot product of a 4-byte column with a 4-byte MixColumns row over GF(2^8) (poly 0x11B).
// Coefficients 1, 2 and 3 only; any other coefficient contributes zero.
module multibly_col_by_row (
  input  logic [31:0] i_col,
  input  logic [31:0] i_row,
  output logic [7:0]  o_byte
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    case (b)
      8'h01:   gf_mul = a;
      8'h02:   gf_mul = xtime(a);
      8'h03:   gf_mul = xtime(a) ^ a;
      default: gf_mul = 8'h00;
    endcase
  endfunction

  always_comb begin
    o_byte = 8'h00;
    for (int k = 0; k < 4; k++)
      o_byte = o_byte ^ gf_mul(i_col[31-8*k -: 8], i_row[31-8*k -: 8]);
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: one result byte per cycle through a shared column-by-row multiplier.
// Optional MIX_BYPASS_EN adds in_bypass, which returns the captured state unchanged (final round).
module mix_columns_seq
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
`ifdef MIX_BYPASS_EN
  ,
  input  logic               in_bypass
`endif
);

  mix_state_t         r_state, w_next;
  logic [3:0]         r_cnt;
  logic [STATE_W-1:0] r_cap;
  logic [STATE_W-1:0] r_res;
  logic               r_out_valid;
  logic [STATE_W-1:0] r_out_data;
  logic               w_byp;

  logic [6:0]         w_col_hi, w_byte_hi;
  logic [31:0]        w_col, w_row;
  logic [7:0]         w_byte;
  logic [STATE_W-1:0] w_res_nxt;

`ifdef MIX_BYPASS_EN
  logic r_byp;
  always_ff @(posedge clk) begin
    if (rst)
      r_byp <= 1'b0;
    else if (r_state == ST_IDLE && in_valid)
      r_byp <= in_bypass;
  end
  assign w_byp = r_byp;
`else
  assign w_byp = 1'b0;
`endif

  // Column c = cnt[3:2] is bytes 4c..4c+3, already packed row 0 in the MSBs.
  assign w_col_hi  = 7'd127 - {r_cnt[3:2], 5'b00000};
  assign w_byte_hi = 7'd127 - {r_cnt, 3'b000};
  assign w_col     = r_cap[w_col_hi -: 32];
  assign w_row     = mix_row(r_cnt[1:0]);

  multibly_col_by_row u_mul (
    .i_col  (w_col),
    .i_row  (w_row),
    .o_byte (w_byte)
  );

  always_comb begin
    w_res_nxt = r_res;
    w_res_nxt[w_byte_hi -: 8] = w_byte;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)      w_next = ST_BUSY;
      ST_BUSY: if (r_cnt == 4'hf) w_next = ST_DONE;
      ST_DONE: if (out_ready)     w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 4'h0;
      r_cap       <= '0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_cap <= in_data;
            r_cnt <= 4'h0;
          end
        end
        ST_BUSY: begin
          r_res <= w_res_nxt;
          if (r_cnt == 4'hf) begin
            // Last byte is folded in here so the result is complete the cycle out_valid rises.
            r_out_valid <= 1'b1;
            r_out_data  <= w_byp ? r_cap : w_res_nxt;
          end else begin
            r_cnt <= r_cnt + 4'h1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: driver pushes expected states, monitor pops on output handshake.
// Also checks accept-to-valid latency, backpressure stability, mid-operation reset and accept spacing.
`timescale 1ns/1ps
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef MIX_BYPASS_EN
  logic         in_bypass;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [127:0] exp_q[$];
  int           acc_q[$];

  localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  // Unit column exposes row orientation; 0x80 column exercises the 0x1b reduction.
  localparam logic [127:0] V3_IN  = 128'h01000000_00000000_80000000_00000000;
  localparam logic [127:0] V3_OUT = 128'h02010103_00000000_1b80809b_00000000;

  mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef MIX_BYPASS_EN
    ,
    .in_bypass (in_bypass)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accept recorder
  initial forever begin
    @(negedge clk);
    if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
  end

  // Monitor: latency on out_valid rise, data on output handshake
  initial begin
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && !prev_v) begin
        if (acc_q.size() == 0) chk("latency_no_accept", 128'd1, 128'd0);
        else chk("latency", 128'(cyc - acc_q.pop_front()), 128'd17);
      end
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", out_data, 128'hx);
        else chk("out_data", out_data, exp_q.pop_front());
      end
      prev_v = out_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [127:0] d, input logic [127:0] e, input logic byp, output int acc);
    bit got;
    got = 0;
    acc = -1;
    in_valid = 1'b1;
    in_data  = d;
`ifdef MIX_BYPASS_EN
    in_bypass = byp;
`else
    if (byp) $display("note: bypass requested on non-bypass build");
`endif
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (got) begin
      exp_q.push_back(e);
      acc = cyc;
    end else begin
      chk("accept_timeout", 128'd0, 128'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int a0, a1;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef MIX_BYPASS_EN
    in_bypass = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);

    // Directed vectors
    send(V1_IN, V1_OUT, 1'b0, a0); wait_drain();
    send(V2_IN, V2_OUT, 1'b0, a0); wait_drain();
    send(V3_IN, V3_OUT, 1'b0, a0); wait_drain();

    // Backpressure, with a competing in_valid that must be ignored
    out_ready = 1'b0;
    send(V1_IN, V1_OUT, 1'b0, a0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    chk("bp_valid_seen", 128'(seen), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = V2_IN;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_data_stable", out_data, V1_OUT);
      chk("bp_in_ready_low", 128'(in_ready), 128'd0);
      chk("bp_valid_held", 128'(out_valid), 128'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_after_hs", 128'(in_ready), 128'd1);
    exp_q.push_back(V2_OUT);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();

    // Reset in the middle of BUSY (cnt=7)
    send(V1_IN, V1_OUT, 1'b0, a0);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_out_data", out_data, 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    send(V2_IN, V2_OUT, 1'b0, a0); wait_drain();

    // Back-to-back with out_ready tied high
    send(V3_IN, V3_OUT, 1'b0, a0);
    send(V1_IN, V1_OUT, 1'b0, a1);
    chk("b2b_spacing", 128'(a1 - a0), 128'd18);
    wait_drain();

`ifdef MIX_BYPASS_EN
    send(128'h00112233_44556677_8899aabb_ccddeeff,
         128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, a0);
    wait_drain();
    send(V1_IN, V1_OUT, 1'b0, a0);
    wait_drain();
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
